// File: rtl/ps2_keyboard_ascii_pkg.sv
// Shared scancode constants, decoder state encoding and keymap entry type.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ps2_keyboard_ascii_pkg;

   // ASCII codes produced for the special keys.
   localparam logic [7:0] ENTER     = 8'h0D;
   localparam logic [7:0] BACKSPACE = 8'h08;
   localparam logic [7:0] BLANK     = 8'h20;

   // Scancode set 2 prefixes and modifier keys.
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

   // One keymap row: unshifted/shifted characters, and whether caps lock applies.
   typedef struct packed {
      logic       mapped;
      logic       letter;
      logic [7:0] lo;
      logic [7:0] hi;
   } rom_ent_t;

   function automatic rom_ent_t letter_ent(input logic [7:0] lo);
      return '{1'b1, 1'b1, lo, lo - 8'h20};
   endfunction

   function automatic rom_ent_t sym_ent(input logic [7:0] lo, input logic [7:0] hi);
      return '{1'b1, 1'b0, lo, hi};
   endfunction

endpackage

// File: rtl/ps2_keyboard_ascii_if.sv
// PS/2 pin inputs and key/status outputs of the keyboard front end.
// Latency: none (wiring only).
// Backpressure: none; outputs are levels and pulses with no ready.
interface ps2_keyboard_ascii_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] kb_input;
   logic       input_valid;
   logic       scan_err;
   logic       overflow;

   modport master (input ps2_clk, ps2_data, output kb_input, input_valid, scan_err, overflow);
   modport slave  (output ps2_clk, ps2_data, input kb_input, input_valid, scan_err, overflow);
endinterface

// File: rtl/ps2_keyboard_ascii_scan2ascii.sv
// Combinational scancode-set-2 to ASCII keymap with shift and caps-lock handling.
// Latency: purely combinational.
// Backpressure: none.
module ps2_scan2ascii import ps2_keyboard_ascii_pkg::*; (
   input  logic [7:0] scancode,
   input  logic       shift,
   input  logic       caps,
   output logic [7:0] ascii,
   output logic       mapped
);
   rom_ent_t ent;

   // Keymap lookup; anything not listed is unmapped.
   always_comb begin
      ent = '0;
      case (scancode)
         8'h1C: ent = letter_ent("a");   8'h32: ent = letter_ent("b");
         8'h21: ent = letter_ent("c");   8'h23: ent = letter_ent("d");
         8'h24: ent = letter_ent("e");   8'h2B: ent = letter_ent("f");
         8'h34: ent = letter_ent("g");   8'h33: ent = letter_ent("h");
         8'h43: ent = letter_ent("i");   8'h3B: ent = letter_ent("j");
         8'h42: ent = letter_ent("k");   8'h4B: ent = letter_ent("l");
         8'h3A: ent = letter_ent("m");   8'h31: ent = letter_ent("n");
         8'h44: ent = letter_ent("o");   8'h4D: ent = letter_ent("p");
         8'h15: ent = letter_ent("q");   8'h2D: ent = letter_ent("r");
         8'h1B: ent = letter_ent("s");   8'h2C: ent = letter_ent("t");
         8'h3C: ent = letter_ent("u");   8'h2A: ent = letter_ent("v");
         8'h1D: ent = letter_ent("w");   8'h22: ent = letter_ent("x");
         8'h35: ent = letter_ent("y");   8'h1A: ent = letter_ent("z");
         8'h16: ent = sym_ent("1", "!"); 8'h1E: ent = sym_ent("2", "@");
         8'h26: ent = sym_ent("3", "#"); 8'h25: ent = sym_ent("4", "$");
         8'h2E: ent = sym_ent("5", "%"); 8'h36: ent = sym_ent("6", "^");
         8'h3D: ent = sym_ent("7", "&"); 8'h3E: ent = sym_ent("8", "*");
         8'h46: ent = sym_ent("9", "("); 8'h45: ent = sym_ent("0", ")");
         8'h0E: ent = sym_ent(8'h60, "~"); 8'h4E: ent = sym_ent("-", "_");
         8'h55: ent = sym_ent("=", "+"); 8'h54: ent = sym_ent("[", "{");
         8'h5B: ent = sym_ent("]", "}"); 8'h5D: ent = sym_ent(8'h5C, "|");
         8'h4C: ent = sym_ent(";", ":"); 8'h52: ent = sym_ent("'", 8'h22);
         8'h41: ent = sym_ent(",", "<"); 8'h49: ent = sym_ent(".", ">");
         8'h4A: ent = sym_ent("/", "?");
         8'h29: ent = sym_ent(BLANK, BLANK);
         8'h5A: ent = sym_ent(ENTER, ENTER);
         8'h66: ent = sym_ent(BACKSPACE, BACKSPACE);
         default: ent = '0;
      endcase
   end

   assign mapped = ent.mapped;
   // Caps lock only inverts the case of letters; symbols follow shift alone.
   assign ascii  = ent.letter ? ((shift ^ caps) ? ent.hi : ent.lo)
                              : (shift ? ent.hi : ent.lo);
endmodule

// File: rtl/ps2_keyboard_ascii.sv
// PS/2 keyboard front end: receive frames, queue scancodes, decode make/break into a held ASCII level.
// Latency: key output registered 2 cycles after the synced stop-bit edge (pin edge + 4 clk) with an empty queue.
// Backpressure: none from downstream; a full scancode queue drops new bytes and sets sticky overflow.
module ps2_keyboard_ascii import ps2_keyboard_ascii_pkg::*; #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 5000
) (
   input logic                  clk,
   input logic                  clrn,
   ps2_keyboard_ascii_if.master kb
);
   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam int              TW        = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]     PTR_ONE   = (AW + 1)'(1);
   localparam logic [TW-1:0]   IDLE_ONE  = TW'(1);
   localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT - 1);

   logic [2:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          fall, data_bit;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] idle_cnt;
   logic          frame_end, frame_ok, push;
   logic          scan_err_q, overflow_q;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, pop, wr_en;
   logic [7:0]    rd_dat;
   dec_state_t    state, state_nxt;
   logic          ev_make, ev_brk, ev_ext;
   logic          lshift, rshift, caps, caps_down;
   logic [7:0]    held, kb_q, rom_ascii, key_ascii;
   logic          vld_q, rom_mapped, key_mapped;

   // Two-flop synchronisers; a third clock flop holds the previous synced level for edge detect.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync <= 3'b111;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[1:0], kb.ps2_clk};
         dat_sync <= {dat_sync[0], kb.ps2_data};
      end
   end

   assign fall     = clk_sync[2] & ~clk_sync[1];
   assign data_bit = dat_sync[1];

   // Stop bit is checked as it arrives so the byte lands in the queue on the same edge.
   assign frame_end = fall && (bit_cnt == 4'd10);
   assign frame_ok  = ~shreg[0] & data_bit & (^shreg[9:1]);
   assign push      = frame_end & frame_ok;

   // Bit receiver with idle timeout that silently abandons a partial frame.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         idle_cnt   <= '0;
         scan_err_q <= 1'b0;
      end else begin
         scan_err_q <= frame_end & ~frame_ok;
         if (fall) begin
            shreg    <= {data_bit, shreg[9:1]};
            bit_cnt  <= frame_end ? 4'd0 : bit_cnt + 4'd1;
            idle_cnt <= '0;
         end else if (bit_cnt != 4'd0) begin
            if (idle_cnt == IDLE_LAST) begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + IDLE_ONE;
            end
         end
      end
   end

   // Scancode queue; a simultaneous pop frees the slot a push needs, even when full.
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop    = ~empty;
   assign wr_en  = push & (~full | pop);
   assign rd_dat = mem[rd_ptr[AW-1:0]];

   // Queue storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg[8:1];
   end

   // Queue pointers and the sticky drop flag.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !wr_en) overflow_q <= 1'b1;
      end
   end

   // Decoder state register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Prefix tracking: classify each popped byte as make or break, plain or extended.
   always_comb begin
      state_nxt = state;
      ev_make   = 1'b0;
      ev_brk    = 1'b0;
      ev_ext    = 1'b0;
      if (pop) begin
         case (state)
            IDLE: begin
               if (rd_dat == SC_BREAK)    state_nxt = BRK;
               else if (rd_dat == SC_EXT) state_nxt = EXT;
               else                       ev_make   = 1'b1;
            end
            BRK: begin
               ev_brk    = 1'b1;
               state_nxt = IDLE;
            end
            EXT: begin
               if (rd_dat == SC_BREAK) begin
                  state_nxt = EXT_BRK;
               end else begin
                  ev_make   = 1'b1;
                  ev_ext    = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: begin
               ev_brk    = 1'b1;
               ev_ext    = 1'b1;
               state_nxt = IDLE;
            end
         endcase
      end
   end

   ps2_scan2ascii u_map (
      .scancode (rd_dat),
      .shift    (lshift | rshift),
      .caps     (caps),
      .ascii    (rom_ascii),
      .mapped   (rom_mapped)
   );

   // Keypad Enter is the only extended key with a character.
   assign key_mapped = ev_ext ? (rd_dat == SC_ENTER) : rom_mapped;
   assign key_ascii  = ev_ext ? ENTER : rom_ascii;

   // Modifier state and held-key outputs; typematic repeats of the held key change nothing.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         lshift    <= 1'b0;
         rshift    <= 1'b0;
         caps      <= 1'b0;
         caps_down <= 1'b0;
         held      <= '0;
         kb_q      <= '0;
         vld_q     <= 1'b0;
      end else begin
         if (ev_make) begin
            if (!ev_ext) begin
               if (rd_dat == SC_LSHIFT) lshift <= 1'b1;
               if (rd_dat == SC_RSHIFT) rshift <= 1'b1;
               if (rd_dat == SC_CAPS && !caps_down) begin
                  caps      <= ~caps;
                  caps_down <= 1'b1;
               end
            end
            if (key_mapped && !(vld_q && rd_dat == held)) begin
               kb_q  <= key_ascii;
               vld_q <= 1'b1;
               held  <= rd_dat;
            end
         end
         if (ev_brk) begin
            if (!ev_ext) begin
               if (rd_dat == SC_LSHIFT) lshift    <= 1'b0;
               if (rd_dat == SC_RSHIFT) rshift    <= 1'b0;
               if (rd_dat == SC_CAPS)   caps_down <= 1'b0;
            end
            if (vld_q && rd_dat == held) begin
               kb_q  <= '0;
               vld_q <= 1'b0;
            end
         end
      end
   end

   assign kb.kb_input    = kb_q;
   assign kb.input_valid = vld_q;
   assign kb.scan_err    = scan_err_q;
   assign kb.overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Directed bench for ps2_keyboard_ascii: bit-banged PS/2 frames with hand-computed expected keys.
// Latency: frame outputs sampled at E, E+1 and E+2 after the stop-bit pin edge.
// Backpressure: decoder stall is produced by forcing the internal pop low.
module tb_ps2_keyboard_ascii;
   localparam int TIMEOUT = 5000;

   logic       clk = 1'b0;
   logic       clrn;
   int         total = 0;
   int         bad = 0;
   logic       se0, se1, se2, v1, v2;
   logic [7:0] k1, k2;
   logic       mon_on = 1'b0;
   logic       mon_glitch = 1'b0;
   logic [7:0] drain_exp [8] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};

   ps2_keyboard_ascii_if kb ();

   ps2_keyboard_ascii #(.FIFO_DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .clrn (clrn),
      .kb   (kb)
   );

   always #5 clk = ~clk;

   // Watch the held Enter output for any dip during typematic repeats.
   always @(negedge clk) begin
      if (mon_on && (kb.input_valid !== 1'b1 || kb.kb_input !== 8'h0D)) mon_glitch = 1'b1;
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      return {~bad_stop, ~(^d) ^ bad_par, d, 1'b0};
   endfunction

   // Drive the first n bits of a frame; on a full frame, sample outputs at E, E+1, E+2.
   task automatic send_raw(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 kb.ps2_data = bits[i];
         repeat (2) @(posedge clk); #1 kb.ps2_clk = 1'b0;
         if (i == 10) begin
            repeat (2) @(posedge clk); #1 se0 = kb.scan_err;
            @(posedge clk); #1 se1 = kb.scan_err; v1 = kb.input_valid; k1 = kb.kb_input;
            @(posedge clk); #1 se2 = kb.scan_err; v2 = kb.input_valid; k2 = kb.kb_input;
         end else begin
            repeat (4) @(posedge clk);
         end
         #1 kb.ps2_clk = 1'b1;
      end
      @(posedge clk); #1 kb.ps2_data = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      send_raw(frame(d, 1'b0, 1'b0), 11);
   endtask

   task automatic key(input logic [7:0] d, input string tag, input logic ev, input logic [7:0] ek);
      send(d);
      check1({tag, " vld"}, v2, ev);
      check8({tag, " key"}, k2, ek);
   endtask

   initial begin
      clrn = 1'b0;
      kb.ps2_clk = 1'b1;
      kb.ps2_data = 1'b1;
      repeat (3) @(posedge clk); #1;
      check8("rst kb_input", kb.kb_input, 8'h00);
      check1("rst input_valid", kb.input_valid, 1'b0);
      check1("rst scan_err", kb.scan_err, 1'b0);
      check1("rst overflow", kb.overflow, 1'b0);
      clrn = 1'b1;
      repeat (3) @(posedge clk);

      // Lower case, then exact latency, then shifted upper case.
      send(8'h1C);
      check1("a E+1 vld", v1, 1'b0);
      check1("a E+2 vld", v2, 1'b1);
      check8("a E+2 key", k2, 8'h61);
      send(8'hF0);
      check1("a held across F0", v2, 1'b1);
      key(8'h1C, "a brk", 1'b0, 8'h00);
      send(8'h12);
      key(8'h1C, "A shift", 1'b1, 8'h41);
      send(8'hF0); key(8'h1C, "A brk", 1'b0, 8'h00);
      send(8'hF0); send(8'h12);

      // Caps lock, caps with shift, and typematic caps repeats toggling once.
      send(8'h58); send(8'hF0); send(8'h58);
      key(8'h1C, "caps A", 1'b1, 8'h41);
      send(8'hF0); send(8'h1C);
      send(8'h12);
      key(8'h1C, "caps shift a", 1'b1, 8'h61);
      send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
      key(8'h1C, "caps once", 1'b1, 8'h61);
      send(8'hF0); send(8'h1C);

      // Digits ignore caps lock; right shift gives the symbol.
      send(8'h58); send(8'hF0); send(8'h58);
      key(8'h16, "1 caps", 1'b1, 8'h31);
      send(8'hF0); send(8'h16);
      send(8'h59);
      key(8'h16, "! rshift", 1'b1, 8'h21);
      send(8'hF0); send(8'h16); send(8'hF0); send(8'h59);
      send(8'h58); send(8'hF0); send(8'h58);

      // Held key with repeats, last key wins, break of a non-held key.
      key(8'h5A, "enter", 1'b1, 8'h0D);
      mon_on = 1'b1;
      send(8'h5A); send(8'h5A); send(8'h5A);
      mon_on = 1'b0;
      check1("enter steady", mon_glitch, 1'b0);
      key(8'h66, "bksp", 1'b1, 8'h08);
      send(8'hF0); key(8'h5A, "other brk", 1'b1, 8'h08);
      send(8'hF0); key(8'h66, "bksp brk", 1'b0, 8'h00);

      // Extended codes: keypad Enter maps, others do not.
      send(8'hE0); key(8'h5A, "ext enter", 1'b1, 8'h0D);
      send(8'hE0); send(8'hF0); key(8'h5A, "ext enter brk", 1'b0, 8'h00);
      send(8'hE0); key(8'h1C, "ext unmapped", 1'b0, 8'h00);

      // Receiver errors with a key held.
      key(8'h29, "space", 1'b1, 8'h20);
      send_raw(frame(8'h1C, 1'b1, 1'b0), 11);
      check1("par err E", se0, 1'b0);
      check1("par err E+1", se1, 1'b1);
      check1("par err E+2", se2, 1'b0);
      check8("par err key", k2, 8'h20);
      send_raw(frame(8'h1C, 1'b0, 1'b1), 11);
      check1("stop err E+1", se1, 1'b1);
      check1("stop err E+2", se2, 1'b0);
      check8("stop err key", k2, 8'h20);
      send(8'hF0); key(8'h29, "space brk", 1'b0, 8'h00);

      // Partial frame abandoned after the idle timeout.
      send_raw(frame(8'h32, 1'b0, 1'b0), 5);
      repeat (TIMEOUT + 1) @(posedge clk);
      key(8'h29, "after timeout", 1'b1, 8'h20);
      send(8'hF0); send(8'h29);

      // Overflow: stall the decoder, push nine bytes, then drain eight in order.
      force dut.pop = 1'b0;
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
      send(8'h24); send(8'h2B); send(8'h34); send(8'h33);
      check1("ovf at full", kb.overflow, 1'b0);
      check1("stalled vld", kb.input_valid, 1'b0);
      send(8'h3B);
      check1("ovf set", kb.overflow, 1'b1);
      @(posedge clk); #1 release dut.pop;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check8($sformatf("drain %0d", i), kb.kb_input, drain_exp[i]);
      end
      repeat (20) @(posedge clk); #1;
      check1("ovf sticky", kb.overflow, 1'b1);
      check8("ninth dropped", kb.kb_input, 8'h68);
      send(8'hF0); key(8'h33, "h brk", 1'b0, 8'h00);

      // Reset in the middle of a frame while a key is held.
      key(8'h29, "pre rst", 1'b1, 8'h20);
      send_raw(frame(8'h1C, 1'b0, 1'b0), 5);
      clrn = 1'b0;
      #1;
      check8("mid rst kb_input", kb.kb_input, 8'h00);
      check1("mid rst input_valid", kb.input_valid, 1'b0);
      check1("mid rst overflow", kb.overflow, 1'b0);
      check1("mid rst scan_err", kb.scan_err, 1'b0);
      repeat (3) @(posedge clk); #1;
      clrn = 1'b1;
      repeat (2) @(posedge clk);
      key(8'h1C, "post rst a", 1'b1, 8'h61);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
